// File: rtl/data_mem_pipe_pkg.sv
// Shared encodings for data_mem_pipe: access sizes, init FSM states and the
// default fill value used by the init sequencer.
package data_mem_pipe_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [31:0] DEF_INIT_VAL = 32'h0000_000A;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

endpackage

// File: rtl/dmem_store_merge.sv
// Combinational lane steering: turns size/offset into a byte-enable mask and
// shifts right-justified store data onto the addressed byte lanes.
module dmem_store_merge
  import data_mem_pipe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]          size_i,
  input  logic [1:0]          offset_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic [DATA_W/8-1:0] be_o,
  output logic [DATA_W-1:0]   wlane_o
);

  localparam int NB = DATA_W / 8;

  always_comb begin
    be_o = '0;
    case (size_i)
      SZ_BYTE: be_o = NB'(1) << offset_i;
      SZ_HALF: be_o = NB'(3) << offset_i;
      SZ_WORD: be_o = '1;
      default: be_o = '0;
    endcase
  end

  assign wlane_o = wdata_i << {offset_i, 3'b000};

endmodule

// File: rtl/data_mem_pipe.sv
// MEM-stage data memory: registered byte/half/word access with valid/ready and a
// post-reset init sequencer. Define DATA_MEM_PIPE_PARITY_EN for per-byte parity.
module data_mem_pipe
  import data_mem_pipe_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 32,
  parameter logic [DATA_W-1:0] INIT_VAL = DATA_W'(DEF_INIT_VAL)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              init_busy,
  output logic              parity_err
);

  localparam int NB = DATA_W / 8;
  localparam int AW = $clog2(DEPTH);

  // Handshake: a request is taken on any rising edge where req_valid && req_ready;
  // exactly one rsp_valid pulse follows on the next cycle, never stalled.

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            init_we;
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_we = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_we = 1'b1;
        cnt_d   = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH - 1)) state_d = ST_IDLE;
      end
      ST_IDLE: state_d = ST_IDLE;
      default: state_d = ST_INIT;
    endcase
  end

  assign req_ready = (state_q == ST_IDLE);
  assign init_busy = (state_q == ST_INIT);

  logic          accept;
  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic          range_err, align_err, req_err;

  assign accept    = req_valid && req_ready;
  assign idx       = req_addr[AW+1:2];
  assign off       = req_addr[1:0];
  assign range_err = (req_addr >> (AW + 2)) != 32'd0;
  assign align_err = ((req_size == SZ_HALF) && off[0]) ||
                     ((req_size == SZ_WORD) && (off != 2'b00));
  assign req_err   = range_err || align_err || (req_size == SZ_RSVD);

  logic [NB-1:0]     be;
  logic [DATA_W-1:0] wlane;

  dmem_store_merge #(.DATA_W(DATA_W)) u_merge (
    .size_i  (req_size),
    .offset_i(off),
    .wdata_i (req_wdata),
    .be_o    (be),
    .wlane_o (wlane)
  );

  // Store lands at the accept edge so a load on the next cycle sees it.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem_q[cnt_q] <= INIT_VAL;
    end else if (accept && req_we && !req_err) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem_q[idx][b*8 +: 8] <= wlane[b*8 +: 8];
      end
    end
  end

  // Load extract mirrors the store steering: mask by the same enables, shift down.
  logic [DATA_W-1:0] rword, rmask, rsel, ld_ext, ld_data;

  assign rword = mem_q[idx];

  always_comb begin
    rmask = '0;
    for (int b = 0; b < NB; b++) rmask[b*8 +: 8] = {8{be[b]}};
  end

  assign rsel = (rword & rmask) >> {off, 3'b000};

  always_comb begin
    ld_ext = rsel;
    if (req_signed) begin
      case (req_size)
        SZ_BYTE: ld_ext = {{(DATA_W-8){rsel[7]}}, rsel[7:0]};
        SZ_HALF: ld_ext = {{(DATA_W-16){rsel[15]}}, rsel[15:0]};
        default: ld_ext = rsel;
      endcase
    end
  end

  assign ld_data = (req_we || req_err) ? '0 : ld_ext;

  logic par_bad;

`ifdef DATA_MEM_PIPE_PARITY_EN
  logic [NB-1:0] par_q [DEPTH];

  function automatic logic [NB-1:0] byte_par(input logic [DATA_W-1:0] w);
    logic [NB-1:0] p;
    for (int b = 0; b < NB; b++) p[b] = ^w[b*8 +: 8];
    return p;
  endfunction

  always_ff @(posedge clk) begin
    if (init_we) begin
      par_q[cnt_q] <= byte_par(INIT_VAL);
    end else if (accept && req_we && !req_err) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) par_q[idx][b] <= ^wlane[b*8 +: 8];
      end
    end
  end

  assign par_bad = accept && !req_we && !req_err && (byte_par(rword) != par_q[idx]);
`else
  assign par_bad = 1'b0;
`endif

  logic              rsp_valid_q, rsp_err_q, par_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      par_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= accept;
      rsp_err_q   <= accept && req_err;
      rsp_rdata_q <= accept ? ld_data : '0;
      par_err_q   <= par_bad;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign parity_err = par_err_q;

endmodule

// File: tb/tb_data_mem_pipe.sv
// Directed-vector bench for data_mem_pipe with an expected-response queue
// drained by an independent monitor.
module tb_data_mem_pipe;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;
  localparam int W      = DATA_W + 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid, req_ready, req_we, req_signed;
  logic [31:0]       req_addr;
  logic [1:0]        req_size;
  logic [DATA_W-1:0] req_wdata, rsp_rdata;
  logic              rsp_valid, rsp_err, init_busy, parity_err;

  int total = 0;
  int bad   = 0;
  int rsp_n = 0;
  logic [W-1:0] exp_q[$];

  data_mem_pipe #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .req_signed(req_signed),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .init_busy (init_busy),
    .parity_err(parity_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rsp_valid) begin
      logic [W-1:0] e;
      rsp_n++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rsp_unexpected #%0d: got data=0x%08h err=%0b par=%0b, none expected",
                 rsp_n, rsp_rdata, rsp_err, parity_err);
      end else begin
        e = exp_q.pop_front();
        if ({parity_err, rsp_err, rsp_rdata} !== e) begin
          bad++;
          $display("FAIL rsp #%0d: got par=%0b err=%0b data=0x%08h want par=%0b err=%0b data=0x%08h",
                   rsp_n, parity_err, rsp_err, rsp_rdata, e[W-1], e[W-2], e[DATA_W-1:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic sgn, input logic [31:0] wdata,
                       input logic [31:0] exp_d, input logic exp_e, input logic exp_p);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_size   = size;
    req_signed = sgn;
    req_wdata  = wdata;
    exp_q.push_back({exp_p, exp_e, exp_d});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic ld(input logic [31:0] addr, input logic [1:0] size, input logic sgn,
                    input logic [31:0] exp_d, input logic exp_e);
    issue(1'b0, addr, size, sgn, 32'h0, exp_d, exp_e, 1'b0);
  endtask

  task automatic st(input logic [31:0] addr, input logic [1:0] size,
                    input logic [31:0] wdata, input logic exp_e);
    issue(1'b1, addr, size, 1'b0, wdata, 32'h0, exp_e, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic load_all_init();
    for (int i = 0; i < DEPTH; i++) ld(32'(i * 4), 2'b10, 1'b0, 32'h0000_000A, 1'b0);
    drain();
  endtask

  initial begin
    int n;
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_size = 2'b00; req_signed = 1'b0; req_wdata = '0;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_init_busy", 32'(init_busy), 32'd1);
    chk("rst_parity_err", 32'(parity_err), 32'd0);

    reset = 1'b1;
    wait_ready(n);
    chk("init_cycles", 32'(n), 32'd32);
    chk("init_busy_after", 32'(init_busy), 32'd0);
    load_all_init();

    // word store then sub-word loads, back to back
    st(32'h10, 2'b10, 32'hDEAD_BEEF, 1'b0);
    ld(32'h13, 2'b00, 1'b1, 32'hFFFF_FFDE, 1'b0);
    ld(32'h13, 2'b00, 1'b0, 32'h0000_00DE, 1'b0);
    ld(32'h10, 2'b00, 1'b0, 32'h0000_00EF, 1'b0);
    ld(32'h12, 2'b01, 1'b1, 32'hFFFF_DEAD, 1'b0);
    ld(32'h10, 2'b01, 1'b0, 32'h0000_BEEF, 1'b0);
    ld(32'h10, 2'b01, 1'b1, 32'hFFFF_BEEF, 1'b0);
    ld(32'h10, 2'b10, 1'b1, 32'hDEAD_BEEF, 1'b0);

    // partial overwrites
    st(32'h20, 2'b10, 32'hDEAD_BEEF, 1'b0);
    st(32'h22, 2'b01, 32'h0000_1234, 1'b0);
    ld(32'h20, 2'b10, 1'b0, 32'h1234_BEEF, 1'b0);
    st(32'h21, 2'b00, 32'h0000_007F, 1'b0);
    ld(32'h20, 2'b10, 1'b0, 32'h1234_7FEF, 1'b0);

    // error cases leave memory untouched
    ld(32'h02, 2'b10, 1'b0, 32'h0, 1'b1);
    ld(32'h80, 2'b10, 1'b0, 32'h0, 1'b1);
    st(32'h90, 2'b10, 32'h5555_5555, 1'b1);
    st(32'h01, 2'b10, 32'h5555_5555, 1'b1);
    st(32'h04, 2'b11, 32'h5555_5555, 1'b1);
    ld(32'h05, 2'b01, 1'b0, 32'h0, 1'b1);
    ld(32'h08, 2'b11, 1'b0, 32'h0, 1'b1);
    ld(32'h00, 2'b10, 1'b0, 32'h0000_000A, 1'b0);
    ld(32'h04, 2'b10, 1'b0, 32'h0000_000A, 1'b0);
    ld(32'h10, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0);
    drain();

`ifdef DATA_MEM_PIPE_PARITY_EN
    st(32'h18, 2'b10, 32'h1122_3344, 1'b0);
    drain();
    dut.mem_q[6] = dut.mem_q[6] ^ 32'h0000_0001;
    ld(32'h18, 2'b10, 1'b0, 32'h1122_3345, 1'b0);
    exp_q[exp_q.size()-1][W-1] = 1'b1;
    ld(32'h1C, 2'b10, 1'b0, 32'h0000_000A, 1'b0);
    drain();
`endif

    // response in flight is dropped by reset
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0; req_size = 2'b10; req_signed = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("inflight_rsp_valid", 32'(rsp_valid), 32'd1);
    reset = 1'b0;
    #1;
    chk("reset_drops_rsp", 32'(rsp_valid), 32'd0);

    // reset mid-init at counter 10
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("midinit_busy", 32'(init_busy), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("midinit_ready_low", 32'(req_ready), 32'd0);
    reset = 1'b1;
    wait_ready(n);
    chk("reinit_cycles", 32'(n), 32'd32);
    load_all_init();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_pipe.md
# data_mem_pipe

Parametrised data memory for the multicycle/pipelined MIPS core's MEM stage. Adds over the current data memory: configurable width and depth, byte/half/word loads and stores with optional sign extension, a registered one-cycle read with valid/ready handshake, alignment and range checking, and a hardware init sequencer that fills every word with a programmable value after reset.

## Interface
- DATA_W, 32: word width in bits; multiple of 8, minimum 32.
- DEPTH, 32: number of words; power of 2, at least 2.
- INIT_VAL, 32'h0000_000A: value written to every word by the init sequencer.
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request this cycle; 0 during init.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (error).
- req_signed  in  1  loads only: sign-extend byte/half result.
- req_wdata  in  DATA_W  store data, right-justified.
- rsp_valid  out  1  one-cycle pulse per accepted request.
- rsp_rdata  out  DATA_W  load result, right-justified; 0 for stores and errors.
- rsp_err  out  1  accepted request was misaligned, out of range or reserved size.
- init_busy  out  1  init sequencer running.
- parity_err  out  1  read parity mismatch (see Configuration).

## Operation
- Word index = req_addr[log2(DEPTH)+1:2]; byte offset = req_addr[1:0].
- Range error: any req_addr bit above log2(DEPTH)+1 set.
- Alignment error: half with offset[0]=1; word with offset != 0.
- Accept when req_valid && req_ready; no other request state is retained.
- Store: byte lanes selected by size/offset written at the accept edge; other lanes unchanged. Errored stores write nothing.
- Load: selected lanes shifted to bit 0; zero-extended unless req_signed; word loads ignore req_signed.
- FSM states: INIT, IDLE. Reset drives INIT with counter = 0. INIT writes INIT_VAL to word[counter] each cycle, increments; after writing word DEPTH-1 moves to IDLE. IDLE is permanent until reset.
- req_ready = (state == IDLE). No response backpressure: consumer always takes rsp.

## Timing
- Reset values: req_ready 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, init_busy 1, parity_err 0.
- Init takes exactly DEPTH cycles after reset release; req_ready rises in cycle DEPTH.
- Load latency 1: accept at edge N, rsp_valid/rsp_rdata/rsp_err valid after edge N, for one cycle.
- Stores also produce rsp_valid one cycle after accept (ack).
- Back-to-back: one request per cycle, full throughput in IDLE.
- Load immediately after store to same word returns the stored data (write completes at the accept edge).
- Reset mid-init or mid-transfer: pending response dropped, sequencer restarts from word 0.

## Configuration
- DATA_MEM_PIPE_PARITY_EN defined: one even-parity bit per byte stored alongside data, written on stores and init; on load all byte parities of the addressed word are checked, and a mismatch sets parity_err with rsp_valid (data still returned).
- Undefined: no parity storage; parity_err tied 0.

## Structure
- data_mem_pipe_pkg: req_size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state enum, default INIT_VAL constant.
- Sub-module dmem_store_merge: from size, offset and wdata, produces byte-enable mask and lane-aligned write data; purely combinational, reused by the load-extract path's mirror logic.

## Test plan
- Reset release, DEPTH=32 -> req_ready low for 32 cycles; then load of every word returns 0x0000000A.
- Store word 0xDEADBEEF at 0x10, load byte 0x13 signed -> 0xFFFFFFDE; unsigned -> 0x000000DE.
- Store half 0x1234 at 0x22 over 0xDEADBEEF -> word load 0x1234BEEF.
- Load word at 0x02 and at 0x80 (DEPTH=32) -> rsp_err=1, rsp_rdata=0, memory unchanged.
- Reset asserted mid-init at counter 10 -> sequencer restarts; all 32 words read 0x0000000A afterwards.
- With DATA_MEM_PIPE_PARITY_EN, force a stored bit flip via hierarchy -> load sets parity_err=1 alongside rsp_valid.
